// File: rtl/adc_frame_align.sv
// Frame-clock aligner: pulses ISERDES bitslip until FRAME_PATTERN is seen MATCH_COUNT times in a row; outputs registered (compare in N -> output in N+1), no backpressure.
// Define ADC_FRAME_ALIGN_STATS_EN to add the saturating realign_count output.
module adc_frame_align #(
  parameter int                    FRAME_BITS    = 8,
  parameter logic [FRAME_BITS-1:0] FRAME_PATTERN = 8'hF0,
  parameter int                    LOCK_WAIT     = 64,
  parameter int                    SETTLE_CYCLES = 4,
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    LOSS_COUNT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    locked,
  input  logic                    restart,
  input  logic [FRAME_BITS-1:0]   frame_data,
  output logic                    bitslip,
  output logic                    aligned,
  output logic                    align_err,
  output logic [$clog2(FRAME_BITS):0] slip_count
`ifdef ADC_FRAME_ALIGN_STATS_EN
  ,
  output logic [7:0]              realign_count
`endif
);

  localparam int SCW = $clog2(FRAME_BITS) + 1;

  typedef enum logic [2:0] {
    WAIT_LOCK, LOCK_DLY, CHECK, SLIP, SETTLE, ALIGNED, FAIL
  } state_t;

  state_t         state, state_nx;
  logic [15:0]    cnt, cnt_nx;
  logic [SCW-1:0] slip_nx;
  logic           match;

  assign match = (frame_data == FRAME_PATTERN);

  // cnt is shared: lock delay, settle time, match run and mismatch run never overlap
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    slip_nx  = slip_count;
    if ((!locked && state != WAIT_LOCK) || restart) begin
      state_nx = WAIT_LOCK;
      cnt_nx   = '0;
      slip_nx  = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt_nx  = '0;
          slip_nx = '0;
          if (locked) state_nx = LOCK_DLY;
        end
        LOCK_DLY: begin
          if (cnt == 16'(LOCK_WAIT - 1)) begin
            state_nx = CHECK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        CHECK: begin
          if (match) begin
            if (cnt == 16'(MATCH_COUNT - 1)) begin
              state_nx = ALIGNED;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 16'd1;
            end
          end else begin
            cnt_nx = '0;
            if (slip_count == SCW'(FRAME_BITS)) begin
              state_nx = FAIL;
            end else begin
              state_nx = SLIP;
              slip_nx  = slip_count + SCW'(1);
            end
          end
        end
        SLIP: begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end
        SETTLE: begin
          if (cnt == 16'(SETTLE_CYCLES - 1)) begin
            state_nx = CHECK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        ALIGNED: begin
          if (match) begin
            cnt_nx = '0;
          end else if (cnt == 16'(LOSS_COUNT - 1)) begin
            state_nx = CHECK;
            cnt_nx   = '0;
            slip_nx  = '0;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        FAIL: begin
          state_nx = FAIL;
        end
        default: begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
          slip_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      slip_count <= '0;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      slip_count <= slip_nx;
      bitslip    <= (state_nx == SLIP);
      aligned    <= (state_nx == ALIGNED);
      align_err  <= (state_nx == FAIL);
    end
  end

`ifdef ADC_FRAME_ALIGN_STATS_EN
  // Leaving ALIGNED for CHECK only happens on a loss-count trip; aborts go to WAIT_LOCK
  logic lost;
  assign lost = (state == ALIGNED) && (state_nx == CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      realign_count <= '0;
    end else if (lost && realign_count != 8'hFF) begin
      realign_count <= realign_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_frame_align.sv
// Scenario bench for adc_frame_align with an ISERDES lane model that rotates the frame word per bitslip.
module tb_adc_frame_align;
  localparam int         FB  = 8;
  localparam logic [7:0] PAT = 8'hF0;
  localparam int         LW  = 64;
  localparam int         SC  = 4;
  localparam int         MC  = 16;
  localparam int         LC  = 4;

  logic       clk = 1'b0;
  logic       reset, locked, restart;
  logic [7:0] frame_data;
  logic       bitslip, aligned, align_err;
  logic [3:0] slip_count;
`ifdef ADC_FRAME_ALIGN_STATS_EN
  logic [7:0] realign_count;
`endif

  int errors = 0;
  int checks = 0;

  // Lane model: word is PAT rotated by lane_off; each observed bitslip moves one position closer
  bit rot_mode = 1'b0;
  int lane_off = 0;

  always #5 clk = ~clk;

  adc_frame_align #(
    .FRAME_BITS(FB), .FRAME_PATTERN(PAT), .LOCK_WAIT(LW),
    .SETTLE_CYCLES(SC), .MATCH_COUNT(MC), .LOSS_COUNT(LC)
  ) dut (
    .clk(clk), .reset(reset), .locked(locked), .restart(restart),
    .frame_data(frame_data), .bitslip(bitslip), .aligned(aligned),
    .align_err(align_err), .slip_count(slip_count)
`ifdef ADC_FRAME_ALIGN_STATS_EN
    , .realign_count(realign_count)
`endif
  );

  function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
    int rr;
    rr = r % 8;
    return 8'((w << rr) | (w >> (8 - rr)));
  endfunction

  function automatic logic [7:0] rand_miss();
    logic [7:0] w;
    do w = 8'($urandom); while (w == PAT);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rot_mode) begin
      if (bitslip) lane_off = (lane_off + 7) % 8;
      frame_data = rotl(PAT, lane_off);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; locked = 1'b0; restart = 1'b0;
    rot_mode = 1'b0; frame_data = 8'h00;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b1; restart = 1'b0; frame_data = PAT;
    repeat (3) step();
    checks++;
    if ({bitslip, aligned, align_err} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {bitslip, aligned, align_err});
    checks++;
    if (slip_count !== 4'd0) $display("FAIL reset_slip_count: got %0d expected 0", slip_count);
`ifdef ADC_FRAME_ALIGN_STATS_EN
    checks++;
    if (realign_count !== 8'd0) $display("FAIL reset_realign: got %0d expected 0", realign_count);
`endif
    errors += ({bitslip, aligned, align_err} !== 3'b000) + (slip_count !== 4'd0);
`ifdef ADC_FRAME_ALIGN_STATS_EN
    errors += (realign_count !== 8'd0);
`endif
    reset = 1'b0;
  endtask

  task automatic test_pattern_correct();
    int n, pulses;
    do_reset();
    frame_data = PAT; locked = 1'b1;
    n = 0; pulses = 0;
    while (!aligned && n < 300) begin
      step(); n++;
      if (bitslip) pulses++;
    end
    checks++;
    if (n !== LW + MC + 1) begin errors++; $display("FAIL direct_align_latency: got %0d expected %0d", n, LW + MC + 1); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL direct_no_slip: got %0d pulses expected 0", pulses); end
    checks++;
    if (slip_count !== 4'd0) begin errors++; $display("FAIL direct_slip_count: got %0d expected 0", slip_count); end
  endtask

  task automatic test_rotation(input int k);
    int n, pulses, last;
    do_reset();
    rot_mode = 1'b1; lane_off = k; frame_data = rotl(PAT, k); locked = 1'b1;
    n = 0; pulses = 0; last = -100;
    while (!aligned && n < 400) begin
      step(); n++;
      if (bitslip) begin
        if (pulses > 0) begin
          checks++;
          if (n - last < SC + 1) begin errors++; $display("FAIL rot%0d_pulse_gap: got %0d expected >= %0d", k, n - last, SC + 1); end
        end
        pulses++; last = n;
      end
    end
    checks++;
    if (pulses !== k) begin errors++; $display("FAIL rot%0d_pulses: got %0d expected %0d", k, pulses, k); end
    checks++;
    if (aligned !== 1'b1) begin errors++; $display("FAIL rot%0d_aligned: got %b expected 1", k, aligned); end
    checks++;
    if (slip_count !== 4'(k)) begin errors++; $display("FAIL rot%0d_slip_count: got %0d expected %0d", k, slip_count, k); end
    checks++;
    if (n !== LW + MC + 1 + k * (SC + 2)) begin errors++; $display("FAIL rot%0d_latency: got %0d expected %0d", k, n, LW + MC + 1 + k * (SC + 2)); end
    rot_mode = 1'b0;
  endtask

  task automatic test_never_match();
    int n, pulses, extra;
    do_reset();
    frame_data = 8'h00; locked = 1'b1;
    n = 0; pulses = 0;
    while (!align_err && n < 500) begin
      step(); n++;
      if (bitslip) pulses++;
    end
    checks++;
    if (pulses !== FB) begin errors++; $display("FAIL fail_pulses: got %0d expected %0d", pulses, FB); end
    checks++;
    if (n !== LW + 2 + FB * (SC + 2)) begin errors++; $display("FAIL fail_latency: got %0d expected %0d", n, LW + 2 + FB * (SC + 2)); end
    checks++;
    if (slip_count !== 4'(FB)) begin errors++; $display("FAIL fail_slip_count: got %0d expected %0d", slip_count, FB); end
    extra = 0;
    repeat (40) begin
      step();
      if (bitslip) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL fail_quiet: got %0d pulses expected 0", extra); end
    checks++;
    if (align_err !== 1'b1) begin errors++; $display("FAIL fail_held: got %b expected 1", align_err); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (align_err !== 1'b0) begin errors++; $display("FAIL restart_err_clear: got %b expected 0", align_err); end
    checks++;
    if (slip_count !== 4'd0) begin errors++; $display("FAIL restart_slip_clear: got %0d expected 0", slip_count); end
    n = 1;
    while (!bitslip && n < 300) begin step(); n++; end
    checks++;
    if (n !== LW + 3) begin errors++; $display("FAIL restart_relock_delay: got %0d expected %0d", n, LW + 3); end
  endtask

  task automatic test_loss_of_alignment();
    int n;
    do_reset();
    frame_data = PAT; locked = 1'b1;
    n = 0;
    while (!aligned && n < 300) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      frame_data = rand_miss(); step();
      checks++;
      if (aligned !== 1'b1) begin errors++; $display("FAIL loss_hold_miss%0d: got %b expected 1", i, aligned); end
    end
    frame_data = PAT; step();
    for (int i = 0; i < 4; i++) begin
      frame_data = rand_miss(); step();
      checks++;
      if (aligned !== (i < 3)) begin errors++; $display("FAIL loss_run_miss%0d: got %b expected %b", i, aligned, i < 3); end
    end
    checks++;
    if (slip_count !== 4'd0) begin errors++; $display("FAIL loss_slip_count: got %0d expected 0", slip_count); end
`ifdef ADC_FRAME_ALIGN_STATS_EN
    checks++;
    if (realign_count !== 8'd1) begin errors++; $display("FAIL loss_realign: got %0d expected 1", realign_count); end
`endif
    frame_data = PAT;
    repeat (MC - 1) step();
    checks++;
    if (aligned !== 1'b0) begin errors++; $display("FAIL realign_early: got %b expected 0", aligned); end
    step();
    checks++;
    if (aligned !== 1'b1) begin errors++; $display("FAIL realign_done: got %b expected 1", aligned); end
`ifdef ADC_FRAME_ALIGN_STATS_EN
    locked = 1'b0; step(); locked = 1'b1; step();
    checks++;
    if (realign_count !== 8'd1) begin errors++; $display("FAIL realign_kept: got %0d expected 1", realign_count); end
`endif
  endtask

  task automatic test_lock_drop_settle();
    int n;
    do_reset();
    rot_mode = 1'b1; lane_off = 3; frame_data = rotl(PAT, 3); locked = 1'b1;
    n = 0;
    while (!bitslip && n < 300) begin step(); n++; end
    step(); step();
    checks++;
    if (bitslip !== 1'b0 || slip_count !== 4'd1) begin
      errors++; $display("FAIL drop_pre_settle: got bitslip=%b slip=%0d expected 0/1", bitslip, slip_count);
    end
    locked = 1'b0;
    step();
    checks++;
    if ({bitslip, aligned, align_err, slip_count} !== 7'd0) begin
      errors++; $display("FAIL drop_outputs: got %b expected 0", {bitslip, aligned, align_err, slip_count});
    end
    locked = 1'b1;
    n = 0;
    while (!bitslip && n < 300) begin step(); n++; end
    checks++;
    if (n !== LW + 2) begin errors++; $display("FAIL drop_relock_delay: got %0d expected %0d", n, LW + 2); end
    checks++;
    if (slip_count !== 4'd1) begin errors++; $display("FAIL drop_slip_restart: got %0d expected 1", slip_count); end
    rot_mode = 1'b0;
  endtask

  task automatic test_reset_during_slip();
    int n;
    do_reset();
    frame_data = 8'h00; locked = 1'b1;
    n = 0;
    while (!bitslip && n < 300) begin step(); n++; end
    reset = 1'b1;
    step();
    checks++;
    if ({bitslip, aligned, align_err, slip_count} !== 7'd0) begin
      errors++; $display("FAIL slip_reset_outputs: got %b expected 0", {bitslip, aligned, align_err, slip_count});
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern_correct();
    test_rotation(3);
    repeat (4) test_rotation($urandom_range(0, 7));
    test_never_match();
    test_loss_of_alignment();
    test_lock_drop_settle();
    test_reset_during_slip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_frame_align.md
Name: adc_frame_align

Overview:
- Sits directly downstream of the ADC MMCM clock generator, in the frame-clock (FCLK) domain.
- Watches the deserialized ADC frame-clock lane and pulses ISERDES bitslip until the word matches the expected frame pattern.
- Declares alignment only after a run of consecutive matches, then monitors for loss of alignment.
- Holds everything idle while the MMCM is unlocked; its `aligned` output gates the ADC data capture path.

Parameters:
- FRAME_BITS, 8, width of the deserialized frame word.
- FRAME_PATTERN, 8'hF0, expected frame word when aligned; width FRAME_BITS.
- LOCK_WAIT, 64, cycles to wait after `locked` rises before the first compare; range 1..65535.
- SETTLE_CYCLES, 4, cycles ignored after each bitslip pulse; range 1..255.
- MATCH_COUNT, 16, consecutive matches required to declare alignment; range 1..255.
- LOSS_COUNT, 4, consecutive mismatches in ALIGNED that trigger realignment; range 1..255.

Ports:
- clk  in  1  frame-rate clock (MMCM FCLK output, via BUFG).
- reset  in  1  synchronous, active-high.
- locked  in  1  MMCM lock status; treated as synchronous to clk.
- restart  in  1  single-cycle request to restart alignment from WAIT_LOCK.
- frame_data  in  FRAME_BITS  deserialized frame-clock lane word, new word every cycle.
- bitslip  out  1  one-cycle pulse to the ISERDES bitslip inputs.
- aligned  out  1  high while in ALIGNED.
- align_err  out  1  high while in FAIL.
- slip_count  out  $clog2(FRAME_BITS)+1  bitslips issued in the current attempt.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state = WAIT_LOCK; bitslip, aligned, align_err = 0; slip_count = 0; all internal counters = 0.
- All outputs are registered. A compare made in cycle N affects outputs in cycle N+1.
- FSM states: WAIT_LOCK, LOCK_DLY, CHECK, SLIP, SETTLE, ALIGNED, FAIL.
- WAIT_LOCK:
  - Clears all counters.
  - Moves to LOCK_DLY when locked = 1.
- LOCK_DLY:
  - Counts LOCK_WAIT cycles.
  - At LOCK_WAIT-1, moves to CHECK with match counter = 0.
- CHECK:
  - Compares frame_data against FRAME_PATTERN each cycle.
  - On match: increments match counter; when it reaches MATCH_COUNT, moves to ALIGNED and sets aligned = 1 the next cycle.
  - On mismatch: clears match counter and moves to SLIP. If slip_count == FRAME_BITS, moves to FAIL instead.
- SLIP:
  - bitslip = 1 for exactly one cycle; slip_count increments.
  - Always followed by SETTLE. bitslip is never high in two consecutive cycles.
- SETTLE:
  - Ignores frame_data for SETTLE_CYCLES cycles, then returns to CHECK with match counter = 0.
- ALIGNED:
  - aligned = 1.
  - Consecutive-mismatch counter increments on mismatch and clears on any match.
  - When it reaches LOSS_COUNT: aligned = 0, slip_count cleared, move to CHECK.
- FAIL:
  - align_err = 1; no bitslip pulses.
  - Exits only on restart, reset, or loss of lock.
- Loss of lock: locked = 0 in any state except WAIT_LOCK moves the FSM to WAIT_LOCK the next cycle and clears aligned, align_err, bitslip and all counters.
- restart: same effect as loss of lock, in every state.
- Priority, highest first: reset > locked = 0 > restart > normal FSM progress.
- A bitslip pulse already issued is never truncated. A mid-SLIP abort drops bitslip the following cycle as normal.
- Counter widths hold their parameter range without wrap; all comparisons are equality.

Optional Feature:
- Macro: ADC_FRAME_ALIGN_STATS_EN.
- When defined, adds output `realign_count` (8 bits):
  - Increments each time ALIGNED is left due to LOSS_COUNT mismatches.
  - Saturates at 8'hFF.
  - Cleared only by reset, not by restart or loss of lock.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Pattern already correct: reset, raise locked, frame_data = 8'hF0 constant -> no bitslip; aligned rises exactly LOCK_WAIT+MATCH_COUNT+1 cycles after locked; slip_count = 0.
- Three rotations needed: model rotates the word once per bitslip, starting 3 positions off -> exactly 3 single-cycle bitslip pulses, each ≥ SETTLE_CYCLES+1 cycles apart; aligned = 1; slip_count = 3.
- Never matches: frame_data = 8'h00 -> exactly 8 bitslip pulses, then align_err = 1 and no further pulses; restart pulse -> align_err = 0, FSM restarts in LOCK_DLY.
- Loss of alignment: from ALIGNED, inject 3 mismatches, then a match, then 4 mismatches -> aligned stays 1 after the 3; drops the cycle after the 4th; realign_count = 1 when ADC_FRAME_ALIGN_STATS_EN is defined.
- Lock drop mid-SETTLE: drop locked for 1 cycle -> next cycle all outputs 0 and slip_count = 0; after relock, full LOCK_WAIT delay is observed again.
- Reset during SLIP: assert reset in the bitslip cycle -> bitslip = 0 the next cycle and every output at its reset value.
